relay_guard_multi: RTL and testbench

//  Parametrised N-channel sensor fault guard: compares each sensor sample against a shared reference and threshold,

---
 rtl/relay_guard_multi.sv | 263 ++++++++++++++++++++++++++
 tb/tb_relay_guard_multi.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_guard_multi.sv
// relay_guard_multi: N-channel sensor fault guard with debounce,
// timed reclosure, retry limit and a valid/ready event stream.
module relay_guard_multi #(
    parameter int N_CH       = 3,
    parameter int SEN_W      = 12,
    parameter int COUNT_MAX  = 800000,
    parameter int DEBOUNCE   = 4,
    parameter int HOLD_TICKS = 63,
    parameter int MAX_RETRY  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH*SEN_W-1:0]   sen_flat,
    input  logic [SEN_W-1:0]        sen_ref,
    input  logic [SEN_W-1:0]        threshold,
    input  logic [N_CH-1:0]         clear_fail,
    output logic [N_CH-1:0]         relay,
    output logic [N_CH-1:0]         fail_latched,
    output logic [3*N_CH-1:0]       ch_state,
    output logic                    evt_valid,
    output logic [$clog2(N_CH):0]   evt_ch,
    output logic [2:0]              evt_code,
    input  logic                    evt_ready,
    output logic                    evt_lost
);

    localparam int CH_W = $clog2(N_CH) + 1;
    localparam int PW   = $clog2(COUNT_MAX);
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int HW   = $clog2(HOLD_TICKS + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] EV_OPEN  = 3'd1;
    localparam logic [2:0] EV_CLOSE = 3'd2;
    localparam logic [2:0] EV_FAIL  = 3'd3;
    localparam logic [2:0] EV_CLR   = 3'd4;
    localparam logic [2:0] EV_RECOV = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MON   = 3'd1,
        S_DEB   = 3'd2,
        S_OPEN  = 3'd3,
        S_CLOSE = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    logic [PW-1:0]    pc_q;
    logic             tick;
    logic [N_CH-1:0]  over;
    logic [SEN_W:0]   diff   [N_CH];
    state_t           st_q   [N_CH];
    state_t           st_d   [N_CH];
    logic [DW-1:0]    deb_q  [N_CH];
    logic [DW-1:0]    deb_d  [N_CH];
    logic [HW-1:0]    hold_q [N_CH];
    logic [HW-1:0]    hold_d [N_CH];
    logic [RW-1:0]    ret_q  [N_CH];
    logic [RW-1:0]    ret_d  [N_CH];
    logic [N_CH-1:0]  trip;
    logic [N_CH-1:0]  ev_set;
    logic [2:0]       ev_code   [N_CH];
    logic [N_CH-1:0]  pend_v;
    logic [2:0]       pend_code [N_CH];
    logic             ld;
    logic             pick_v;
    logic [CH_W-1:0]  pick_ch;
    logic [2:0]       pick_code;
    logic [N_CH-1:0]  take;

    assign tick = (pc_q == PW'(COUNT_MAX - 1));

    // Free-running tick prescaler, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pc_q <= '0;
        else if (tick) pc_q <= '0;
        else           pc_q <= pc_q + PW'(1);
    end

    // Over-threshold test in SEN_W+1 bits so a low sample never wraps.
    always_comb begin
        over = '0;
        for (int i = 0; i < N_CH; i++) begin
            diff[i] = {1'b0, sen_flat[i*SEN_W +: SEN_W]} - {1'b0, sen_ref};
            over[i] = !diff[i][SEN_W] && (diff[i][SEN_W-1:0] > threshold);
        end
    end

    // Per-channel next state, counters and event generation.
    always_comb begin
        trip   = '0;
        ev_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]    = st_q[i];
            deb_d[i]   = deb_q[i];
            hold_d[i]  = hold_q[i];
            ret_d[i]   = ret_q[i];
            ev_code[i] = 3'd0;
            if (st_q[i] == S_FAIL) begin
                if (clear_fail[i]) begin
                    st_d[i]    = en ? S_MON : S_IDLE;
                    ret_d[i]   = '0;
                    deb_d[i]   = '0;
                    hold_d[i]  = '0;
                    ev_set[i]  = 1'b1;
                    ev_code[i] = EV_CLR;
                end
            end else if (!en) begin
                st_d[i]   = S_IDLE;
                ret_d[i]  = '0;
                deb_d[i]  = '0;
                hold_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    S_IDLE: begin
                        st_d[i]  = S_MON;
                        ret_d[i] = '0;
                    end
                    S_MON: begin
                        if (tick && over[i]) begin
                            st_d[i]  = S_DEB;
                            deb_d[i] = DW'(1);
                            trip[i]  = (DEBOUNCE == 1);
                        end
                    end
                    S_DEB: begin
                        if (tick && !over[i]) begin
                            st_d[i]   = (ret_q[i] == '0) ? S_MON : S_CLOSE;
                            deb_d[i]  = '0;
                            hold_d[i] = '0;
                        end else if (tick) begin
                            deb_d[i] = deb_q[i] + DW'(1);
                            trip[i]  = (deb_d[i] == DW'(DEBOUNCE));
                        end
                    end
                    S_OPEN: begin
                        if (tick) begin
                            hold_d[i] = hold_q[i] + HW'(1);
                            if (hold_d[i] == HW'(HOLD_TICKS)) begin
                                st_d[i]    = S_CLOSE;
                                hold_d[i]  = '0;
                                ev_set[i]  = 1'b1;
                                ev_code[i] = EV_CLOSE;
                            end
                        end
                    end
                    S_CLOSE: begin
                        if (tick && over[i]) begin
                            st_d[i]   = S_DEB;
                            deb_d[i]  = DW'(1);
                            hold_d[i] = '0;
                            trip[i]   = (DEBOUNCE == 1);
                        end else if (tick) begin
                            hold_d[i] = hold_q[i] + HW'(1);
                            if (hold_d[i] == HW'(HOLD_TICKS)) begin
                                st_d[i]    = S_MON;
                                hold_d[i]  = '0;
                                ret_d[i]   = '0;
                                ev_set[i]  = 1'b1;
                                ev_code[i] = EV_RECOV;
                            end
                        end
                    end
                    default: st_d[i] = S_IDLE;
                endcase
                if (trip[i]) begin
                    deb_d[i]  = '0;
                    hold_d[i] = '0;
                    ev_set[i] = 1'b1;
                    if (ret_q[i] == RW'(MAX_RETRY)) begin
                        st_d[i]    = S_FAIL;
                        ev_code[i] = EV_FAIL;
                    end else begin
                        st_d[i]    = S_OPEN;
                        ret_d[i]   = ret_q[i] + RW'(1);
                        ev_code[i] = EV_OPEN;
                    end
                end
            end
        end
    end

    // Channel state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= S_IDLE;
                deb_q[i]  <= '0;
                hold_q[i] <= '0;
                ret_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= st_d[i];
                deb_q[i]  <= deb_d[i];
                hold_q[i] <= hold_d[i];
                ret_q[i]  <= ret_d[i];
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        relay        = '0;
        fail_latched = '0;
        ch_state     = '0;
        for (int i = 0; i < N_CH; i++) begin
            relay[i]          = (st_q[i] == S_OPEN) || (st_q[i] == S_FAIL);
            fail_latched[i]   = (st_q[i] == S_FAIL);
            ch_state[3*i +: 3] = st_q[i];
        end
    end

    // Lowest-index pending slot wins the output register.
    always_comb begin
        ld        = !evt_valid || evt_ready;
        pick_v    = 1'b0;
        pick_ch   = '0;
        pick_code = '0;
        take      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_v[i]) begin
                pick_v    = 1'b1;
                pick_ch   = CH_W'(i);
                pick_code = pend_code[i];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            take[i] = ld && pick_v && (pick_ch == CH_W'(i));
        end
    end

    // Pending slots and the held output event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_code  <= '0;
            evt_lost  <= 1'b0;
            pend_v    <= '0;
            for (int i = 0; i < N_CH; i++) pend_code[i] <= '0;
        end else begin
            if (ld) begin
                evt_valid <= pick_v;
                if (pick_v) begin
                    evt_ch   <= pick_ch;
                    evt_code <= pick_code;
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (ev_set[i]) begin
                    pend_v[i]    <= 1'b1;
                    pend_code[i] <= ev_code[i];
                    if (pend_v[i] && !take[i]) evt_lost <= 1'b1;
                end else if (take[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_relay_guard_multi.sv
// tb_relay_guard_multi: scoreboard bench for relay_guard_multi
// against a tick-level behavioural model of each channel.
module tb_relay_guard_multi;

    localparam int CM = 4;
    localparam int DB = 2;
    localparam int HT = 3;
    localparam int MR = 2;

    localparam int IDLE = 0;
    localparam int MON  = 1;
    localparam int DEBS = 2;
    localparam int OPN  = 3;
    localparam int CLS  = 4;
    localparam int FL   = 5;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] sen_v [3];
    logic [35:0] sen_flat;
    logic [11:0] ref_v;
    logic [11:0] thr_v;
    logic [2:0]  clr;
    logic [2:0]  relay;
    logic [2:0]  fail_latched;
    logic [8:0]  ch_state;
    logic        evt_valid;
    logic [2:0]  evt_ch;
    logic [2:0]  evt_code;
    logic        evt_ready;
    logic        evt_lost;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_on   = 1;

    int m_md   [3];
    int m_run  [3];
    int m_hold [3];
    int m_try  [3];
    int m_pc;
    bit m_tick;
    int exp_q [3][$];

    assign sen_flat = {sen_v[2], sen_v[1], sen_v[0]};

    relay_guard_multi #(
        .N_CH(3), .SEN_W(12), .COUNT_MAX(CM),
        .DEBOUNCE(DB), .HOLD_TICKS(HT), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .sen_flat(sen_flat), .sen_ref(ref_v),
        .threshold(thr_v), .clear_fail(clr),
        .relay(relay), .fail_latched(fail_latched),
        .ch_state(ch_state), .evt_valid(evt_valid),
        .evt_ch(evt_ch), .evt_code(evt_code),
        .evt_ready(evt_ready), .evt_lost(evt_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // A channel's behaviour over one clock, in tick-level terms.
    task automatic model_ch(input int i, input bit tk);
        bit bad;
        bad = (int'(sen_v[i]) - int'(ref_v)) > int'(thr_v);
        if (m_md[i] == FL) begin
            if (clr[i]) begin
                m_md[i]  = en ? MON : IDLE;
                m_try[i] = 0;
                exp_q[i].push_back(4);
            end
            return;
        end
        if (!en) begin
            m_md[i] = IDLE;
            m_run[i] = 0; m_hold[i] = 0; m_try[i] = 0;
            return;
        end
        if (m_md[i] == IDLE) begin
            m_md[i] = MON;
            m_try[i] = 0;
            return;
        end
        if (!tk) return;
        case (m_md[i])
            MON: if (bad) begin m_md[i] = DEBS; m_run[i] = 1; end
            DEBS: begin
                if (bad) m_run[i]++;
                else begin
                    m_run[i] = 0; m_hold[i] = 0;
                    m_md[i] = (m_try[i] == 0) ? MON : CLS;
                end
            end
            OPN: begin
                m_hold[i]++;
                if (m_hold[i] == HT) begin
                    m_md[i] = CLS; m_hold[i] = 0;
                    exp_q[i].push_back(2);
                end
            end
            CLS: begin
                if (bad) begin
                    m_md[i] = DEBS; m_run[i] = 1; m_hold[i] = 0;
                end else begin
                    m_hold[i]++;
                    if (m_hold[i] == HT) begin
                        m_md[i] = MON; m_hold[i] = 0; m_try[i] = 0;
                        exp_q[i].push_back(5);
                    end
                end
            end
            default: ;
        endcase
        if (m_md[i] == DEBS && m_run[i] >= DB) begin
            m_run[i] = 0;
            if (m_try[i] == MR) begin
                m_md[i] = FL;
                exp_q[i].push_back(3);
            end else begin
                m_try[i]++; m_hold[i] = 0; m_md[i] = OPN;
                exp_q[i].push_back(1);
            end
        end
    endtask

    // Reference model advances on every clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 0;
            for (int i = 0; i < 3; i++) begin
                m_md[i] = IDLE; m_run[i] = 0;
                m_hold[i] = 0; m_try[i] = 0;
                exp_q[i].delete();
            end
        end else begin
            m_tick = (m_pc == CM - 1);
            m_pc = m_tick ? 0 : m_pc + 1;
            for (int i = 0; i < 3; i++) model_ch(i, m_tick);
        end
    end

    // Monitor: state outputs every cycle, events on handshake.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("ch_state", 32'(ch_state[3*i +: 3]), m_md[i]);
                chk("relay", 32'(relay[i]),
                    (m_md[i] == OPN || m_md[i] == FL) ? 1 : 0);
                chk("fail_latched", 32'(fail_latched[i]),
                    (m_md[i] == FL) ? 1 : 0);
            end
            if (sb_on) chk("evt_lost_mon", 32'(evt_lost), 0);
            if (sb_on && evt_valid && evt_ready) begin
                n_tests++;
                if (evt_ch > 2 || exp_q[evt_ch].size() == 0) begin
                    n_fail++;
                    $display("FAIL evt_unexpected: got ch %0d code %0d required none",
                             evt_ch, evt_code);
                end else begin
                    int e;
                    e = exp_q[evt_ch].pop_front();
                    if (32'(evt_code) != e) begin
                        n_fail++;
                        $display("FAIL evt_code ch%0d: got %0d expected %0d",
                                 evt_ch, evt_code, e);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            #1;
            if (m_pc == 0) k++;
        end
    endtask

    function automatic logic [11:0] pick_sen();
        int v;
        case ($urandom_range(0, 5))
            0: v = int'(ref_v) + int'(thr_v);
            1: v = int'(ref_v) + int'(thr_v) + 1;
            2: v = int'(ref_v) - 1;
            3: v = int'(ref_v);
            4: v = int'(ref_v) + int'(thr_v) + int'($urandom_range(2, 500));
            default: v = int'($urandom_range(0, 4095));
        endcase
        return 12'(v);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; clr = '0; evt_ready = 1'b1;
        ref_v = 12'd100; thr_v = 12'd20;
        for (int c = 0; c < 3; c++) sen_v[c] = 12'd100;
        #1 rst = 1'b0;
        #2;
        chk("rst_relay", 32'(relay), 0);
        chk("rst_state", 32'(ch_state), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_evt_ch", 32'(evt_ch), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_lost", 32'(evt_lost), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: excess equal to threshold never trips; one more trips
        en = 1'b1; sen_v[0] = 12'd120;
        wait_ticks(10);
        chk("t1_no_trip_relay", 32'(relay[0]), 0);
        chk("t1_no_trip_state", 32'(ch_state[2:0]), MON);
        sen_v[0] = 12'd121;
        wait_ticks(2);
        chk("t1_relay", 32'(relay[0]), 1);
        chk("t1_valid_pre", 32'(evt_valid), 0);
        step(1);
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_evt_ch", 32'(evt_ch), 0);
        chk("t1_code", 32'(evt_code), 1);
        sen_v[0] = 12'd100;

        // 2: sample below reference
        sen_v[1] = 12'd50;
        wait_ticks(20);
        chk("t2_state", 32'(ch_state[5:3]), MON);
        chk("t2_relay", 32'(relay[1]), 0);
        sen_v[1] = 12'd100;

        // 3: persistent fault runs out of retries
        sen_v[0] = 12'd200;
        wait_ticks(12);
        chk("t3_fail", 32'(fail_latched[0]), 1);
        chk("t3_relay", 32'(relay[0]), 1);
        wait_ticks(2);
        chk("t3_hold", 32'(ch_state[2:0]), FL);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("t3_clr_relay", 32'(relay[0]), 0);
        chk("t3_clr_state", 32'(ch_state[2:0]), MON);
        sen_v[0] = 12'd100;
        wait_ticks(1);

        // 4: back-pressure with two simultaneous events
        evt_ready = 1'b0;
        sen_v[0] = 12'd200; sen_v[2] = 12'd200;
        wait_ticks(2);
        step(1);
        chk("t4_valid", 32'(evt_valid), 1);
        chk("t4_ch0", 32'(evt_ch), 0);
        step(2);
        chk("t4_hold_ch", 32'(evt_ch), 0);
        chk("t4_hold_code", 32'(evt_code), 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("t4_ch2", 32'(evt_ch), 2);
        chk("t4_code2", 32'(evt_code), 1);
        chk("t4_valid2", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        step(1);
        sen_v[0] = 12'd100; sen_v[2] = 12'd100;
        wait_ticks(8);
        chk("t4_lost", 32'(evt_lost), 0);

        // 6: recovery in CLOSE resets the retry count
        sen_v[0] = 12'd200;
        wait_ticks(7);
        sen_v[0] = 12'd100;
        wait_ticks(6);
        chk("t6_recovered", 32'(ch_state[2:0]), MON);
        sen_v[0] = 12'd200;
        wait_ticks(2);
        chk("t6_open", 32'(ch_state[2:0]), OPN);
        sen_v[0] = 12'd100;
        wait_ticks(6);

        // 5: en drop keeps FAIL; reset drops relays at once
        sen_v[1] = 12'd200;
        wait_ticks(12);
        chk("t5_fail1", 32'(ch_state[5:3]), FL);
        sen_v[0] = 12'd200;
        wait_ticks(2);
        en = 1'b0;
        step(1);
        chk("t5_en_idle", 32'(ch_state[2:0]), IDLE);
        chk("t5_en_relay", 32'(relay[0]), 0);
        chk("t5_en_fail", 32'(ch_state[5:3]), FL);
        chk("t5_en_relay1", 32'(relay[1]), 1);
        step(2);
        en = 1'b1;
        wait_ticks(1);
        wait_ticks(2);
        chk("t5_open", 32'(ch_state[2:0]), OPN);
        step(1);
        #3 rst = 1'b0;
        #1;
        chk("t5_rst_relay", 32'(relay), 0);
        chk("t5_rst_state", 32'(ch_state), 0);
        chk("t5_rst_valid", 32'(evt_valid), 0);
        chk("t5_rst_fail", 32'(fail_latched), 0);
        for (int c = 0; c < 3; c++) sen_v[c] = 12'd100;
        @(posedge clk);
        #1 rst = 1'b1;
        wait_ticks(1);

        // randomized traffic, inputs aligned to tick periods
        for (int p = 0; p < 80; p++) begin
            if ($urandom_range(0, 7) == 0) begin
                ref_v = 12'($urandom_range(0, 4095));
                thr_v = 12'($urandom_range(0, 300));
            end
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 2) == 0) sen_v[c] = pick_sen();
            step(3);
            if ($urandom_range(0, 3) == 0)
                clr = 3'($urandom_range(0, 7));
            step(1);
            clr = '0;
        end

        // settle everything back to MONITOR
        ref_v = 12'd100; thr_v = 12'd20;
        for (int c = 0; c < 3; c++) sen_v[c] = 12'd100;
        clr = 3'b111; en = 1'b0;
        step(1);
        clr = '0; en = 1'b1;
        wait_ticks(2);
        for (int c = 0; c < 3; c++)
            chk("sb_empty", exp_q[c].size(), 0);
        chk("lost_clean", 32'(evt_lost), 0);

        // overwrite of an unconsumed slot sets evt_lost
        sb_on = 1'b0;
        evt_ready = 1'b0;
        sen_v[0] = 12'd200;
        wait_ticks(7);
        step(1);
        chk("lost_set", 32'(evt_lost), 1);
        chk("lost_hold_code", 32'(evt_code), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
